// File: rtl/smachine_pkg.sv
// Shared constants for the S-Machine data memory: MMIO register offsets,
// bus direction encodings and the size of the MMIO window at the top of the address space.
package smachine_pkg;

  localparam int MMIO_WORDS = 8;

  localparam logic [2:0] OFF_LED  = 3'd0;
  localparam logic [2:0] OFF_SW   = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_MASK = 3'd3;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/smachine_switch_debounce.sv
// One switch input: 2-flop synchroniser followed, when SMACHINE_DEBOUNCE_EN is
// defined, by a stability counter that gates changes into the accepted state.
module smachine_switch_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SMACHINE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // The count is the number of consecutive cycles the synced value has
  // disagreed with the accepted state; the DEBOUNCE_CYCLES-th one commits it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_q2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign stable = sync_q2;
`endif

endmodule

// File: rtl/smachine_mmio_data_memory.sv
// S-Machine data memory: word RAM at the bottom of the map, GPIO bank (LED, switch
// state, W1C edge flags, IRQ mask) in the top 8 words. Debounce via SMACHINE_DEBOUNCE_EN.
module smachine_mmio_data_memory
  import smachine_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int ADDR_W          = 9,
  parameter int DEPTH           = 256,
  parameter int N_LED           = 2,
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_en,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in_memory,
  output logic [DATA_W-1:0] data_out_memory,
  input  logic [N_SW-1:0]   switch,
  output logic [N_LED-1:0]  led,
  output logic              irq
);

  localparam int MMIO_BASE = 2**ADDR_W - MMIO_WORDS;
  localparam int RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] MMIO_BASE_A = ADDR_W'(MMIO_BASE);

  logic [DATA_W-1:0] ram [DEPTH];

  logic [N_LED-1:0] led_reg;
  logic [N_SW-1:0]  sw_state;
  logic [N_SW-1:0]  sw_prev;
  logic [N_SW-1:0]  edge_reg;
  logic [N_SW-1:0]  mask_reg;
  logic [N_SW-1:0]  w1c;

  logic             wr_en;
  logic             rd_en;
  logic             in_ram;
  logic             in_mmio;
  logic             mmio_wr;
  logic [2:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;

  assign wr_en    = mem_en && (read_write == RW_WRITE);
  assign rd_en    = mem_en && (read_write == RW_READ);
  assign in_ram   = (addr < DEPTH_A);
  assign in_mmio  = (addr >= MMIO_BASE_A);
  assign mmio_wr  = wr_en && in_mmio;
  assign mmio_off = addr[2:0];
  assign ram_idx  = addr[RAM_AW-1:0];

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    smachine_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (switch[i]),
      .stable (sw_state[i])
    );
  end

  // RAM has no reset; a write in flight when reset asserts may or may not land.
  always_ff @(posedge clk) begin
    if (wr_en && in_ram) begin
      ram[ram_idx] <= data_in_memory;
    end
  end

  assign w1c = (mmio_wr && mmio_off == OFF_EDGE) ? data_in_memory[N_SW-1:0] : '0;

  // Edge flags compare the accepted state against its previous value; a new
  // edge is OR-ed in after the W1C so it survives a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg  <= '0;
      sw_prev  <= '0;
      edge_reg <= '0;
      mask_reg <= '0;
    end else begin
      sw_prev  <= sw_state;
      edge_reg <= (edge_reg & ~w1c) | (sw_state ^ sw_prev);
      if (mmio_wr && mmio_off == OFF_LED) begin
        led_reg <= data_in_memory[N_LED-1:0];
      end
      if (mmio_wr && mmio_off == OFF_MASK) begin
        mask_reg <= data_in_memory[N_SW-1:0];
      end
    end
  end

  always_comb begin
    data_out_memory = '0;
    if (rd_en) begin
      if (in_ram) begin
        data_out_memory = ram[ram_idx];
      end else if (in_mmio) begin
        case (mmio_off)
          OFF_LED:  data_out_memory[N_LED-1:0] = led_reg;
          OFF_SW:   data_out_memory[N_SW-1:0]  = sw_state;
          OFF_EDGE: data_out_memory[N_SW-1:0]  = edge_reg;
          OFF_MASK: data_out_memory[N_SW-1:0]  = mask_reg;
          default:  data_out_memory = '0;
        endcase
      end
    end
  end

  assign led = led_reg;
  assign irq = |(edge_reg & mask_reg);

endmodule

// File: tb/tb_smachine_mmio_data_memory.sv
// Bench for smachine_mmio_data_memory with default parameters; switch timing
// expectations follow SMACHINE_DEBOUNCE_EN.
module tb_smachine_mmio_data_memory;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 256;
  localparam int N_LED  = 2;
  localparam int N_SW   = 2;
  localparam int DB     = 1000;
`ifdef SMACHINE_DEBOUNCE_EN
  localparam int SW_LAT = DB + 2;
`else
  localparam int SW_LAT = 2;
`endif

  localparam logic [ADDR_W-1:0] A_LED  = 9'h1F8;
  localparam logic [ADDR_W-1:0] A_SW   = 9'h1F9;
  localparam logic [ADDR_W-1:0] A_EDGE = 9'h1FA;
  localparam logic [ADDR_W-1:0] A_MASK = 9'h1FB;

  logic              clk;
  logic              rst_n;
  logic              mem_en;
  logic              read_write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in_memory;
  logic [DATA_W-1:0] data_out_memory;
  logic [N_SW-1:0]   switch;
  logic [N_LED-1:0]  led;
  logic              irq;

  int checks;
  int errors;
  logic [DATA_W-1:0] exp_q[$];

  typedef struct {
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp_rd;
    logic [N_LED-1:0]  exp_led;
  } vec_t;

  vec_t tbl[18];

  smachine_mmio_data_memory dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_en          (mem_en),
    .read_write      (read_write),
    .addr            (addr),
    .data_in_memory  (data_in_memory),
    .data_out_memory (data_out_memory),
    .switch          (switch),
    .led             (led),
    .irq             (irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic en, input logic rw, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    @(negedge clk);
    mem_en = en; read_write = rw; addr = a; data_in_memory = d;
    #1;
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    drive(1'b1, 1'b1, a, d);
    @(posedge clk);
    #1;
    mem_en = 1'b0;
  endtask

  task automatic peek(input logic [ADDR_W-1:0] a);
    mem_en = 1'b1; read_write = 1'b0; addr = a;
    #1;
  endtask

  // Drive one switch and count edges until SW_STATE shows the new value.
  task automatic sw_step(input int idx, input logic val, input int exp_lat, input string name);
    int  n;
    bit  found;
    @(negedge clk);
    switch[idx] = val;
    mem_en = 1'b1; read_write = 1'b0; addr = A_SW;
    n = 0; found = 0;
    while (!found && n < SW_LAT + 50) begin
      @(posedge clk); #1;
      n++;
      if (data_out_memory[idx] === val) found = 1;
    end
    check(name, n, exp_lat);
  endtask

  // Randomised bus traffic against a plain register/array model.
  task automatic random_phase(input int n_ops);
    logic [DATA_W-1:0] ram_m [int];
    logic [N_LED-1:0]  led_m;
    logic [N_SW-1:0]   mask_m;
    logic [N_SW-1:0]   edge_m;
    logic [DATA_W-1:0] exp_v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic en;
    logic rw;
    int   region;
    led_m = 2'b01; mask_m = 2'b11; edge_m = '0;
    for (int k = 0; k < n_ops; k++) begin
      region = int'($urandom_range(0, 3));
      case (region)
        0, 1:    a = ADDR_W'($urandom_range(16, DEPTH - 1));
        2:       a = ADDR_W'($urandom_range(DEPTH, 9'h1F7));
        default: a = ADDR_W'($urandom_range(9'h1F8, 9'h1FF));
      endcase
      d  = DATA_W'($urandom);
      en = ($urandom_range(0, 7) != 0);
      rw = $urandom_range(0, 1) == 1;
      if (a < DEPTH && !rw && !ram_m.exists(int'(a))) rw = 1'b1;
      exp_v = '0;
      if (en && !rw) begin
        if (a < DEPTH) exp_v = ram_m[int'(a)];
        else if (a == A_LED)  exp_v = DATA_W'(led_m);
        else if (a == A_EDGE) exp_v = DATA_W'(edge_m);
        else if (a == A_MASK) exp_v = DATA_W'(mask_m);
      end
      exp_q.push_back(exp_v);
      drive(en, rw, a, d);
      check("rand_read", data_out_memory, exp_q.pop_front());
      if (en && rw) begin
        if (a < DEPTH) ram_m[int'(a)] = d;
        else if (a == A_LED)  led_m  = d[N_LED-1:0];
        else if (a == A_MASK) mask_m = d[N_SW-1:0];
        else if (a == A_EDGE) edge_m = edge_m & ~d[N_SW-1:0];
      end
      @(posedge clk); #1;
      check("rand_led", led, led_m);
      check("rand_irq", irq, |(edge_m & mask_m));
    end
    mem_en = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; mem_en = 1'b0; read_write = 1'b0; addr = '0;
    data_in_memory = '0; switch = '0;

    // Reset state
    #1;
    check("rst_led", led, 2'b00);
    check("rst_irq", irq, 1'b0);
    peek(A_SW);   check("rst_sw", data_out_memory, 16'h0000);
    peek(A_EDGE); check("rst_edge", data_out_memory, 16'h0000);
    peek(A_MASK); check("rst_mask", data_out_memory, 16'h0000);
    mem_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven bus vectors
    tbl[0]  = '{1, 1, 9'h005, 16'h1234, 16'h0000, 2'b00};
    tbl[1]  = '{1, 0, 9'h005, 16'h0000, 16'h1234, 2'b00};
    tbl[2]  = '{1, 1, A_LED,  16'h0003, 16'h0000, 2'b11};
    tbl[3]  = '{1, 0, A_LED,  16'h0000, 16'h0003, 2'b11};
    tbl[4]  = '{1, 0, 9'h1F0, 16'h0000, 16'h0000, 2'b11};
    tbl[5]  = '{0, 0, 9'h005, 16'h0000, 16'h0000, 2'b11};
    tbl[6]  = '{0, 1, 9'h005, 16'hFFFF, 16'h0000, 2'b11};
    tbl[7]  = '{1, 0, 9'h005, 16'h0000, 16'h1234, 2'b11};
    tbl[8]  = '{1, 1, A_LED,  16'hFFFE, 16'h0000, 2'b10};
    tbl[9]  = '{1, 0, A_LED,  16'h0000, 16'h0002, 2'b10};
    tbl[10] = '{1, 1, 9'h100, 16'hABCD, 16'h0000, 2'b10};
    tbl[11] = '{1, 0, 9'h100, 16'h0000, 16'h0000, 2'b10};
    tbl[12] = '{1, 0, 9'h1FF, 16'h0000, 16'h0000, 2'b10};
    tbl[13] = '{1, 1, A_MASK, 16'hFFFF, 16'h0000, 2'b10};
    tbl[14] = '{1, 0, A_MASK, 16'h0000, 16'h0003, 2'b10};
    tbl[15] = '{1, 0, A_SW,   16'h0000, 16'h0000, 2'b10};
    tbl[16] = '{1, 1, 9'h0FF, 16'h8001, 16'h0000, 2'b10};
    tbl[17] = '{1, 0, 9'h0FF, 16'h0000, 16'h8001, 2'b10};
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].en, tbl[i].rw, tbl[i].a, tbl[i].wd);
      check($sformatf("tbl_rd[%0d]", i), data_out_memory, tbl[i].exp_rd);
      @(posedge clk); #1;
      check($sformatf("tbl_led[%0d]", i), led, tbl[i].exp_led);
    end
    write(A_LED, 16'h0001);

    random_phase(300);

    // Edge capture and IRQ
    write(A_MASK, 16'h0001);
    write(A_EDGE, 16'hFFFF);
    sw_step(0, 1'b1, SW_LAT, "sw0_rise_latency");
    @(posedge clk); #1;
    peek(A_EDGE); check("edge_after_rise", data_out_memory, 16'h0001);
    check("irq_after_rise", irq, 1'b1);
    write(A_EDGE, 16'h0001);
    check("irq_after_w1c", irq, 1'b0);
    peek(A_EDGE); check("edge_after_w1c", data_out_memory, 16'h0000);

    // W1C landing on the same edge that sets the flag
    sw_step(0, 1'b0, SW_LAT, "sw0_fall_latency");
    write(A_EDGE, 16'h0001);
    peek(A_EDGE); check("edge_coincident", data_out_memory, 16'h0001);
    check("irq_coincident", irq, 1'b1);
    write(A_EDGE, 16'h0001);
    check("irq_cleared", irq, 1'b0);

`ifdef SMACHINE_DEBOUNCE_EN
    // One-cycle glitch halfway through the debounce window restarts the count
    begin
      int n;
      int set_at;
      @(negedge clk);
      switch[0] = 1'b1;
      peek(A_SW);
      n = 0; set_at = 0;
      while (set_at == 0 && n < 2 + 500 + 1 + DB + 50) begin
        @(posedge clk); #1;
        n++;
        if (n == 2 + DB) check("glitch_hold_at_1002", data_out_memory[0], 1'b0);
        if (data_out_memory[0] === 1'b1) set_at = n;
        if (n == 500) begin @(negedge clk); switch[0] = 1'b0; end
        if (n == 501) begin @(negedge clk); switch[0] = 1'b1; end
      end
      check("glitch_set_cycle", set_at, 2 + 500 + 1 + DB);
    end
`else
    sw_step(0, 1'b1, SW_LAT, "sw0_rise2_latency");
`endif

    sw_step(1, 1'b1, SW_LAT, "sw1_rise_latency");
    @(posedge clk); #1;

    // Reset asserted while switch 0 is mid-debounce
    write(A_LED, 16'h0003);
    check("pre_rst_led", led, 2'b11);
    check("pre_rst_irq", irq, 1'b1);
    peek(A_EDGE); check("pre_rst_edge", data_out_memory, 16'h0003);
    @(negedge clk);
    switch[0] = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_led", led, 2'b00);
    check("mid_rst_irq", irq, 1'b0);
    peek(A_EDGE); check("mid_rst_edge", data_out_memory, 16'h0000);
    peek(A_SW);   check("mid_rst_sw", data_out_memory, 16'h0000);
    peek(A_MASK); check("mid_rst_mask", data_out_memory, 16'h0000);
    peek(9'h005); check("mid_rst_ram5", data_out_memory, 16'h1234);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_led", led, 2'b00);
    peek(9'h005); check("post_rst_ram5", data_out_memory, 16'h1234);
    mem_en = 1'b0;

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
